// File: rtl/cla_pkg.sv
// Shared types and helpers for the sequential nibble-sliced CLA adder.
package cla_pkg;

  localparam int unsigned NIB = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cla_state_t;

  function automatic int unsigned nslices(input int unsigned width);
    return width / NIB;
  endfunction

endpackage

// File: rtl/cla_seq_adder_if.sv
// Operand/result handshake bundle between issue logic and the sequential adder.
interface cla_seq_adder_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             Sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             Ovf;

  modport master (
    output in_valid, A, B, Cin, Sub, out_ready,
    input  in_ready, out_valid, Sum, Cout, Ovf
  );

  modport slave (
    input  in_valid, A, B, Cin, Sub, out_ready,
    output in_ready, out_valid, Sum, Cout, Ovf
  );
endinterface

// File: rtl/cla_seq_adder_cla4.sv
// 4-bit carry-look-ahead adder: the single datapath slice reused every cycle.
module CLA_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  assign p = a ^ b;
  assign g = a & b;

  // Carries flattened from generate/propagate; no ripple between bits.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum  = p ^ c[3:0];
  assign cout = c[4];
endmodule

// File: rtl/cla_seq_adder.sv
// Multi-cycle add/subtract: one CLA_4bit walks the operands LSB nibble first,
// the inter-slice carry living in carry_q.
module cla_seq_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  cla_seq_adder_if.slave  bus
);
  localparam int unsigned NS  = nslices(WIDTH);
  localparam int unsigned KW  = (NS > 1) ? $clog2(NS) : 1;
  localparam int unsigned MSB = WIDTH - 1;

  generate
    if ((WIDTH % NIB) != 0 || WIDTH < NIB) begin : g_bad_width
      $error("cla_seq_adder: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  cla_state_t       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             ovf_q;
  logic [KW-1:0]    k_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [NIB-1:0]   a_nib;
  logic [NIB-1:0]   b_nib;
  logic [NIB-1:0]   cla_sum;
  logic             cla_cout;
  logic             last_slice;

  // Slice mux: shift by k*4 and keep the low nibble.
  assign a_nib      = NIB'(a_q >> {k_q, 2'b00});
  assign b_nib      = NIB'(b_q >> {k_q, 2'b00});
  assign last_slice = (k_q == KW'(NS - 1));

  CLA_4bit u_cla (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry_q),
    .sum  (cla_sum),
    .cout (cla_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      k_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Subtraction is folded into the add: A + ~B + ~borrow.
          if (bus.in_valid && in_ready_q) begin
            a_q        <= bus.A;
            b_q        <= bus.Sub ? ~bus.B : bus.B;
            carry_q    <= bus.Sub ? ~bus.Cin : bus.Cin;
            k_q        <= '0;
            in_ready_q <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < int'(NS); i++) begin
            if (k_q == KW'(i)) sum_q[i*NIB +: NIB] <= cla_sum;
          end
          carry_q <= cla_cout;
          if (last_slice) begin
            ovf_q       <= (a_q[MSB] == b_q[MSB]) && (cla_sum[NIB-1] != a_q[MSB]);
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.Sum       = sum_q;
  assign bus.Cout      = carry_q;
  assign bus.Ovf       = ovf_q;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed bench for cla_seq_adder (WIDTH=16) with hand-computed results.
module tb_cla_seq_adder;
  localparam int unsigned WIDTH = 16;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  cla_seq_adder_if #(.WIDTH(WIDTH)) bus ();

  cla_seq_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub);
    bus.A        = a;
    bus.B        = b;
    bus.Cin      = cin;
    bus.Sub      = sub;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Wait for out_valid after an accept; checks latency and the result.
  task automatic wait_result(input string tag, input logic [15:0] es,
                             input logic ec, input logic eo);
    int n;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_val({tag, "_valid"},   32'(bus.out_valid), 32'd1);
    check_val({tag, "_latency"}, 32'(n), 32'd4);
    check_val({tag, "_sum"},     32'(bus.Sum), 32'(es));
    check_val({tag, "_cout"},    32'(bus.Cout), 32'(ec));
    check_val({tag, "_ovf"},     32'(bus.Ovf), 32'(eo));
  endtask

  task automatic take_result(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check_val({tag, "_ready_after"}, 32'(bus.in_ready), 32'd1);
    check_val({tag, "_valid_after"}, 32'(bus.out_valid), 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub,
                        input logic [15:0] es, input logic ec, input logic eo);
    start_op(a, b, cin, sub);
    wait_result(tag, es, ec, eo);
    take_result(tag);
  endtask

  initial begin
    n_checks      = 0;
    n_pass        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.Cin       = 1'b0;
    bus.Sub       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_in_ready",  32'(bus.in_ready), 32'd1);
    check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("rst_sum",       32'(bus.Sum), 32'd0);
    check_val("rst_cout",      32'(bus.Cout), 32'd0);
    check_val("rst_ovf",       32'(bus.Ovf), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op("add",      16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_op("ripple",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("sub_b0",   16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_b1",   16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0);
    run_op("ovf_add",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("ovf_sub",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_op("cin_wrap", 16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);

    // Back-pressure: stall in DONE while new operands are offered.
    start_op(16'h1111, 16'h2222, 1'b0, 1'b0);
    wait_result("bp", 16'h3333, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      bus.A        = 16'hFFFF;
      bus.B        = 16'hFFFF;
      bus.Cin      = 1'b1;
      bus.Sub      = 1'b0;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      check_val("bp_valid_hold", 32'(bus.out_valid), 32'd1);
      check_val("bp_sum_hold",   32'(bus.Sum), 32'h3333);
      check_val("bp_cout_hold",  32'(bus.Cout), 32'd0);
      check_val("bp_in_ready",   32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    take_result("bp");
    run_op("post_bp", 16'h0100, 16'h0200, 1'b0, 1'b0, 16'h0300, 1'b0, 1'b0);

    // Reset in the middle of RUN, two slices in.
    start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check_val("mid_rst_ready", 32'(bus.in_ready), 32'd1);
    check_val("mid_rst_cout",  32'(bus.Cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op("post_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cla_seq_adder.md
# cla_seq_adder

Multi-cycle WIDTH-bit add/subtract unit that sequences a single shared `CLA_4bit` through WIDTH/4 nibble slices, LSB first, with the carry held in a register between slices. Operands are accepted on a valid/ready input handshake and the result is returned on a valid/ready output handshake. The block sits between the arithmetic issue logic and the result bus. It trades latency for area: one 4-bit carry-look-ahead adder serves any operand width.

## Interface
- `WIDTH`, default 16: operand width; must be a multiple of 4 and at least 4 (elaboration-time check).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operand request.
- `in_ready` out 1: block can accept; high only in IDLE.
- `A` in WIDTH: operand A, sampled at the accept edge.
- `B` in WIDTH: operand B, sampled at the accept edge.
- `Cin` in 1: carry-in when Sub=0; borrow-in when Sub=1.
- `Sub` in 1: 0 computes A+B+Cin; 1 computes A−B−Cin.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer takes the result.
- `Sum` out WIDTH: result.
- `Cout` out 1: final carry out. When Sub=1, 1 means no borrow.
- `Ovf` out 1: two's-complement signed overflow.

## Operation
- NS = WIDTH/4 slices. States are IDLE, RUN and DONE.
- **IDLE:**
  - in_ready=1.
  - When in_valid&&in_ready: latch A into a_q; latch B into b_q, inverted if Sub=1.
  - Set carry_q = Sub ? ~Cin : Cin.
  - Set slice index k=0, then go to RUN.
- **RUN:**
  - The CLA is fed a_q[4k+3:4k], b_q[4k+3:4k] and carry_q.
  - At each edge, its 4-bit sum is written to sum_q[4k+3:4k] and its Cout to carry_q; k increments.
  - On the edge that writes slice NS−1, go to DONE.
  - Also on that edge, register Ovf = (a_q[MSB]==b_q[MSB]) && (slice MSB sum != a_q[MSB]).
- **DONE:**
  - out_valid=1; Sum=sum_q, Cout=carry_q, Ovf held.
  - On out_valid&&out_ready, go to IDLE.
- Subtraction is always A + ~B + ~Cin. There is no separate subtractor.
- in_valid is ignored outside IDLE (in_ready=0). Operands presented during RUN or DONE are not captured.
- Sum, Cout and Ovf are defined only while out_valid=1. At other times they hold their last register value (partial slices are visible during RUN).
- Only one operation is in flight at a time. There is no accept in DONE, even when out_ready=1 in the same cycle.
- k wraps never: RUN exits exactly at k=NS−1. WIDTH=4 means RUN lasts one cycle.

## Timing
- **Reset values (asynchronous, rst_n low):**
  - State is IDLE, so in_ready=1.
  - out_valid=0.
  - Sum, Cout, Ovf, a_q, b_q, carry_q and k are all 0.
- **Reset mid-operation:** abort immediately. No result is produced and no carry survives. The next accepted operation starts clean.
- **Latency:** out_valid rises NS rising edges after the accept edge (4 edges for WIDTH=16).
- **Throughput:** one operation per NS+2 cycles, minimum (accept, NS RUN edges, output handshake, return to IDLE).
- **Back-pressure:**
  - While out_valid && !out_ready, Sum/Cout/Ovf/out_valid are held stable.
  - in_ready=1 in the cycle after the output handshake edge.
- **Critical path:** the CLA_4bit carry chain plus the 4-bit slice mux. It is independent of WIDTH.

## Structure
- Package `cla_pkg`:
  - `cla_state_t` enum (IDLE, RUN, DONE).
  - `NIB` = 4 localparam.
  - Function `nslices(width)` returns width/NIB.
- Sub-module: exactly one instance of the existing `CLA_4bit`, the shared datapath.
- Control (FSM and k counter) and slice muxing live in `cla_seq_adder`.

## Test plan
1. **Basic add.** WIDTH=16, A=16'h1234, B=16'h4321, Cin=0, Sub=0.
   - Required: Sum=16'h5555, Cout=0, Ovf=0.
   - out_valid 4 edges after accept.
2. **Full ripple.** A=16'hFFFF, B=16'h0001, Cin=0, Sub=0.
   - Required: Sum=16'h0000, Cout=1, Ovf=0.
   - Carry crosses all 4 slices.
3. **Subtract with borrow.**
   - A=16'h0005, B=16'h0007, Sub=1, Cin=0 must give Sum=16'hFFFE, Cout=0.
   - Repeating with Cin=1 must give Sum=16'hFFFD, Cout=0.
4. **Signed overflow.**
   - A=16'h7FFF, B=16'h0001, Sub=0 must give Sum=16'h8000, Ovf=1, Cout=0.
   - A=16'h8000, B=16'h0001, Sub=1 must give Sum=16'h7FFF, Ovf=1.
5. **Back-pressure.** Hold out_ready=0 for 3 cycles in DONE and pulse in_valid with new operands.
   - Required: Sum, Cout and out_valid stay stable, in_ready=0, and the new operands are not captured.
   - After the handshake, in_ready=1 on the next cycle and a new op completes correctly.
6. **Reset mid-RUN.** Assert rst_n=0 at k=2 of an FFFF+0001 op.
   - Required: out_valid=0 and in_ready=1 immediately.
   - After release, 0001+0001 yields Sum=16'h0002, Cout=0 (no stale carry).
